imm_decode_stage: RTL

Registered, parametrised immediate-decode pipeline stage between instruction fetch and the execute/branch units. Accepts one 32-bit instruction plus its PC per valid/ready handshake and produces:
- the sign- or zero-extended XLEN-wide immediate,
- a format tag,
- an illegal-opcode flag,
- the precomputed PC-relative target.

A two-entry skid buffer gives full throughput under backpressure, and a synchronous flush discards in-flight entries on redirect.

---
 rtl/imm_pkg.sv | 35 +++
 rtl/imm_extract.sv | 84 ++++++++
 rtl/imm_decode_stage.sv | 99 +++++++++
 3 files changed

// File: rtl/imm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : imm_pkg
// Description : Opcodes, format tags and shared widths for immediate decode.
// Revision    : 1.0 - initial release
// ============================================================================
package imm_pkg;

    localparam int FMT_W = 3;

    typedef enum logic [FMT_W-1:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_Z    = 3'd6
    } imm_fmt_e;

    localparam logic [6:0] c_OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] c_OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] c_OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] c_OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] c_OPC_STORE     = 7'b0100011;
    localparam logic [6:0] c_OPC_OP        = 7'b0110011;
    localparam logic [6:0] c_OPC_LUI       = 7'b0110111;
    localparam logic [6:0] c_OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] c_OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] c_OPC_JALR      = 7'b1100111;
    localparam logic [6:0] c_OPC_JAL       = 7'b1101111;
    localparam logic [6:0] c_OPC_SYSTEM    = 7'b1110011;

endpackage
`default_nettype wire

// File: rtl/imm_extract.sv
`default_nettype none
// ============================================================================
// Module      : imm_extract
// Description : Combinational opcode-to-format/immediate decoder.
//               Macro IMM_DECODE_ZICSR_EN enables SYSTEM (CSR-immediate) decode.
// Revision    : 1.0 - initial release
// ============================================================================
module imm_extract
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]      instr,
    output logic [XLEN-1:0]  imm,
    output logic [FMT_W-1:0] fmt,
    output logic             illegal
);

    logic [31:0] w_imm32;

    // Every format fits a 32-bit sign-extended value; widen once at the end.
    always_comb begin
        w_imm32 = '0;
        fmt     = FMT_NONE;
        illegal = 1'b0;
        if (instr[1:0] != 2'b11) begin
            illegal = 1'b1;
        end else begin
            case (instr[6:0])
                c_OPC_OP_IMM, c_OPC_LOAD, c_OPC_JALR: begin
                    fmt     = FMT_I;
                    w_imm32 = {{20{instr[31]}}, instr[31:20]};
                end
                c_OPC_STORE: begin
                    fmt     = FMT_S;
                    w_imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
                end
                c_OPC_BRANCH: begin
                    fmt     = FMT_B;
                    w_imm32 = {{19{instr[31]}}, instr[31], instr[7],
                               instr[30:25], instr[11:8], 1'b0};
                end
                c_OPC_LUI, c_OPC_AUIPC: begin
                    fmt     = FMT_U;
                    w_imm32 = {instr[31:12], 12'b0};
                end
                c_OPC_JAL: begin
                    fmt     = FMT_J;
                    w_imm32 = {{12{instr[31]}}, instr[19:12], instr[20],
                               instr[30:21], 1'b0};
                end
                c_OPC_OP: begin
                    fmt = FMT_NONE;
                end
                c_OPC_OP_IMM_32: begin
                    if (XLEN == 64) begin
                        fmt     = FMT_I;
                        w_imm32 = {{20{instr[31]}}, instr[31:20]};
                    end else begin
                        illegal = 1'b1;
                    end
                end
                c_OPC_OP_32: begin
                    illegal = (XLEN != 64);
                end
`ifdef IMM_DECODE_ZICSR_EN
                c_OPC_SYSTEM: begin
                    if (instr[14]) begin
                        fmt     = FMT_Z;
                        w_imm32 = {27'b0, instr[19:15]};
                    end
                end
`endif
                default: begin
                    illegal = 1'b1;
                end
            endcase
        end
    end

    assign imm = XLEN'($signed(w_imm32));

endmodule
`default_nettype wire

// File: rtl/imm_decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : imm_decode_stage
// Description : Registered immediate-decode stage with two-entry skid buffer.
//               Macro IMM_DECODE_ZICSR_EN is honoured by imm_extract.
// Revision    : 1.0 - initial release
// ============================================================================
module imm_decode_stage
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [XLEN-1:0]  in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [FMT_W-1:0] out_fmt,
    output logic [XLEN-1:0]  out_target,
    output logic             out_illegal
);

    localparam int c_PW = 2*XLEN + FMT_W + 1;

    logic [XLEN-1:0]  w_imm;
    logic [FMT_W-1:0] w_fmt;
    logic             w_illegal;
    logic             w_pcrel;
    logic [XLEN-1:0]  w_target;
    logic [c_PW-1:0]  w_payload;
    logic             w_accept;
    logic             w_main_free;

    logic             r_main_valid;
    logic             r_skid_valid;
    logic             r_in_ready;
    logic [c_PW-1:0]  r_main_data;
    logic [c_PW-1:0]  r_skid_data;

    imm_extract #(
        .XLEN    (XLEN)
    ) u_extract (
        .instr   (in_instr),
        .imm     (w_imm),
        .fmt     (w_fmt),
        .illegal (w_illegal)
    );

    // JALR is excluded: its base is rs1, resolved downstream.
    assign w_pcrel   = (w_fmt == FMT_B) || (w_fmt == FMT_J) ||
                       (!w_illegal && in_instr[6:0] == c_OPC_AUIPC);
    assign w_target  = w_pcrel ? (in_pc + w_imm) : '0;
    assign w_payload = {w_imm, w_fmt, w_target, w_illegal};

    assign w_accept    = in_valid && r_in_ready;
    assign w_main_free = !r_main_valid || out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b0;
            r_main_data  <= '0;
            r_skid_data  <= '0;
        end else if (flush) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b1;
        end else if (w_main_free) begin
            // in_ready is low whenever skid is occupied, so no accept collides here.
            if (r_skid_valid) begin
                r_main_data  <= r_skid_data;
                r_main_valid <= 1'b1;
                r_skid_valid <= 1'b0;
            end else begin
                r_main_valid <= w_accept;
                if (w_accept) begin
                    r_main_data <= w_payload;
                end
            end
            r_in_ready <= 1'b1;
        end else if (w_accept) begin
            r_skid_data  <= w_payload;
            r_skid_valid <= 1'b1;
            r_in_ready   <= 1'b0;
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_main_valid;
    assign {out_imm, out_fmt, out_target, out_illegal} = r_main_data;

endmodule
`default_nettype wire
